// File: rtl/alu_exec_if.sv
// Issue and result bus for the dual-lane ALU execution block.
// The master drives issues and the slave returns forwarded results and status.
interface alu_exec_if #(
  parameter int ROB_W  = 6,
  parameter int DATA_W = 16
);
  localparam int FW = 1 + ROB_W + DATA_W;

  logic [3:0]        inOperation0, inOperation1;
  logic [ROB_W-1:0]  inROB0, inROB1;
  logic [DATA_W-1:0] inValue0A, inValue0B, inValue1A, inValue1B;
  logic              inReady0, inReady1;
  logic [FW-1:0]     forward0, forward1, forwardDiv;
  logic              busy0, busy1, divBusy, dropErr;

  modport master (
    output inOperation0, inOperation1, inROB0, inROB1,
           inValue0A, inValue0B, inValue1A, inValue1B, inReady0, inReady1,
    input  forward0, forward1, forwardDiv, busy0, busy1, divBusy, dropErr
  );

  modport slave (
    input  inOperation0, inOperation1, inROB0, inROB1,
           inValue0A, inValue0B, inValue1A, inValue1B, inReady0, inReady1,
    output forward0, forward1, forwardDiv, busy0, busy1, divBusy, dropErr
  );
endinterface

// File: rtl/alu_exec.sv
// Two independent ALU lanes (single-cycle ops plus a 2-stage multiply)
// sharing one radix-2 restoring divider that takes 16 iterations.
module alu_exec #(
  parameter int ROB_W  = 6,
  parameter int DATA_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam int FW = 1 + ROB_W + DATA_W;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIVU, OP_REMU, OP_PASSA, OP_PASSB, OP_RSVD
  } opcode_e;

  typedef enum logic {DIV_IDLE, DIV_RUN} divState_e;

  function automatic logic [DATA_W-1:0] aluResult(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (opcode_e'(op))
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SHL:   r = a << b[3:0];
      OP_SHR:   r = a >> b[3:0];
      OP_SRA:   r = $signed(a) >>> b[3:0];
      OP_SLT:   r = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  r = {{(DATA_W-1){1'b0}}, a < b};
      OP_MUL:   r = a * b;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [3:0]        laneOp    [2];
  logic [ROB_W-1:0]  laneTag   [2];
  logic [DATA_W-1:0] laneA     [2];
  logic [DATA_W-1:0] laneB     [2];
  logic              laneReady [2];

  assign laneOp[0]    = bus.inOperation0;
  assign laneOp[1]    = bus.inOperation1;
  assign laneTag[0]   = bus.inROB0;
  assign laneTag[1]   = bus.inROB1;
  assign laneA[0]     = bus.inValue0A;
  assign laneA[1]     = bus.inValue1A;
  assign laneB[0]     = bus.inValue0B;
  assign laneB[1]     = bus.inValue1B;
  assign laneReady[0] = bus.inReady0;
  assign laneReady[1] = bus.inReady1;

  logic [FW-1:0]     fwdQ    [2];
  logic              mulValid[2];
  logic [ROB_W-1:0]  mulTag  [2];
  logic [DATA_W-1:0] mulProd [2];
  logic              accept  [2];
  logic              isDiv   [2];
  logic              isMul   [2];
  logic [DATA_W-1:0] laneRes [2];

  // A lane is blocked only during the second multiply stage.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      accept[l]  = laneReady[l] && !mulValid[l];
      isMul[l]   = laneOp[l] == OP_MUL;
      isDiv[l]   = (laneOp[l] == OP_DIVU) || (laneOp[l] == OP_REMU);
      laneRes[l] = aluResult(laneOp[l], laneA[l], laneB[l]);
    end
  end

  divState_e         divState, divNext;
  logic [4:0]        divCnt;
  logic [DATA_W-1:0] divRem, divQuo, divDen, remNext, quoNext;
  logic [DATA_W:0]   remShift, diff;
  logic [ROB_W-1:0]  divTag;
  logic              divIsRem;
  logic [FW-1:0]     fwdDiv;
  logic              divTake0, divTake1, startDiv, dropNow, dropErrQ;

  assign divTake0 = accept[0] && isDiv[0] && (divState == DIV_IDLE);
  assign divTake1 = accept[1] && isDiv[1] && (divState == DIV_IDLE) && !divTake0;
  assign startDiv = divTake0 || divTake1;
  assign dropNow  = (laneReady[0] && mulValid[0]) || (laneReady[1] && mulValid[1]) ||
                    (accept[0] && isDiv[0] && !divTake0) ||
                    (accept[1] && isDiv[1] && !divTake1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        fwdQ[l]     <= '0;
        mulValid[l] <= 1'b0;
        mulTag[l]   <= '0;
        mulProd[l]  <= '0;
      end
      dropErrQ <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        mulValid[l] <= accept[l] && isMul[l];
        mulTag[l]   <= laneTag[l];
        mulProd[l]  <= laneRes[l];
        if (mulValid[l])
          fwdQ[l] <= {1'b1, mulTag[l], mulProd[l]};
        else if (accept[l] && !isMul[l] && !isDiv[l])
          fwdQ[l] <= {1'b1, laneTag[l], laneRes[l]};
        else
          fwdQ[l] <= '0;
      end
      dropErrQ <= dropErrQ || dropNow;
    end
  end

  // Divider control plus one restoring step; a zero divisor naturally
  // yields an all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    divNext = divState;
    case (divState)
      DIV_IDLE: if (startDiv) divNext = DIV_RUN;
      DIV_RUN:  if (divCnt == 5'd1) divNext = DIV_IDLE;
      default:  divNext = DIV_IDLE;
    endcase
    remShift = {divRem, divQuo[DATA_W-1]};
    diff     = remShift - {1'b0, divDen};
    remNext  = diff[DATA_W] ? remShift[DATA_W-1:0] : diff[DATA_W-1:0];
    quoNext  = {divQuo[DATA_W-2:0], ~diff[DATA_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divState <= DIV_IDLE;
      divCnt   <= '0;
      divRem   <= '0;
      divQuo   <= '0;
      divDen   <= '0;
      divTag   <= '0;
      divIsRem <= 1'b0;
      fwdDiv   <= '0;
    end else begin
      divState <= divNext;
      fwdDiv   <= '0;
      if (startDiv) begin
        divCnt   <= 5'd16;
        divRem   <= '0;
        divQuo   <= divTake0 ? laneA[0] : laneA[1];
        divDen   <= divTake0 ? laneB[0] : laneB[1];
        divTag   <= divTake0 ? laneTag[0] : laneTag[1];
        divIsRem <= divTake0 ? (laneOp[0] == OP_REMU) : (laneOp[1] == OP_REMU);
      end else if (divState == DIV_RUN) begin
        divCnt <= divCnt - 5'd1;
        divRem <= remNext;
        divQuo <= quoNext;
        if (divCnt == 5'd1)
          fwdDiv <= {1'b1, divTag, divIsRem ? remNext : quoNext};
      end
    end
  end

  assign bus.forward0   = fwdQ[0];
  assign bus.forward1   = fwdQ[1];
  assign bus.forwardDiv = fwdDiv;
  assign bus.busy0      = mulValid[0];
  assign bus.busy1      = mulValid[1];
  assign bus.divBusy    = divState == DIV_RUN;
  assign bus.dropErr    = dropErrQ;
endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a vector table for the single-cycle ops plus
// hand-written sequences for multiply, divider, drop and reset-abort cases.
module tb_alu_exec;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SHL = 4'd5,  OP_SHR = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8,  OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12, OP_PASSA = 4'd13, OP_PASSB = 4'd14, OP_RSVD = 4'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if #(.ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();
  alu_exec #(.ROB_W(ROB_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          lane;
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] want;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [22:0] busVal(input logic [5:0] tag, input logic [15:0] v);
    return {1'b1, tag, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  task automatic clearInputs();
    bus.inOperation0 = '0; bus.inOperation1 = '0;
    bus.inROB0 = '0;       bus.inROB1 = '0;
    bus.inValue0A = '0;    bus.inValue0B = '0;
    bus.inValue1A = '0;    bus.inValue1B = '0;
    bus.inReady0 = 1'b0;   bus.inReady1 = 1'b0;
  endtask

  task automatic applyStimulus(input int lane, input logic [3:0] op, input logic [5:0] tag,
                               input logic [15:0] a, input logic [15:0] b);
    if (lane == 0) begin
      bus.inOperation0 = op; bus.inROB0 = tag;
      bus.inValue0A = a; bus.inValue0B = b; bus.inReady0 = 1'b1;
    end else begin
      bus.inOperation1 = op; bus.inROB1 = tag;
      bus.inValue1A = a; bus.inValue1B = b; bus.inReady1 = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic runDiv(input int lane, input logic [3:0] op, input logic [5:0] tag,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] want,
                        input string name);
    applyStimulus(lane, op, tag, a, b);
    step();
    clearInputs();
    checkOutput({name, " lane bus"}, (lane == 0) ? bus.forward0 : bus.forward1, 0);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) step();
      checkOutput({name, " divBusy"}, bus.divBusy, 1);
      checkOutput({name, " early forwardDiv"}, bus.forwardDiv, 0);
    end
    step();
    checkOutput(name, bus.forwardDiv, busVal(tag, want));
    checkOutput({name, " divBusy done"}, bus.divBusy, 0);
  endtask

  initial begin
    vecs[0]  = '{0, OP_ADD,   6'd5,  16'h7FFF, 16'h0001, 16'h8000};
    vecs[1]  = '{1, OP_SUB,   6'd63, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[2]  = '{0, OP_AND,   6'd1,  16'hF0F0, 16'h3C3C, 16'h3030};
    vecs[3]  = '{1, OP_OR,    6'd2,  16'hF0F0, 16'h0F01, 16'hFFF1};
    vecs[4]  = '{0, OP_XOR,   6'd3,  16'hAAAA, 16'hFFFF, 16'h5555};
    vecs[5]  = '{1, OP_SHL,   6'd4,  16'h0001, 16'h0013, 16'h0008};
    vecs[6]  = '{0, OP_SHR,   6'd6,  16'h8000, 16'h000F, 16'h0001};
    vecs[7]  = '{1, OP_SRA,   6'd7,  16'h8000, 16'h0004, 16'hF800};
    vecs[8]  = '{0, OP_SLT,   6'd8,  16'hFFFF, 16'h0001, 16'h0001};
    vecs[9]  = '{1, OP_SLTU,  6'd9,  16'hFFFF, 16'h0001, 16'h0000};
    vecs[10] = '{0, OP_SLT,   6'd10, 16'h0001, 16'hFFFF, 16'h0000};
    vecs[11] = '{1, OP_SLTU,  6'd11, 16'h0001, 16'hFFFF, 16'h0001};
    vecs[12] = '{0, OP_PASSA, 6'd12, 16'h1234, 16'h5678, 16'h1234};
    vecs[13] = '{1, OP_PASSB, 6'd13, 16'h1234, 16'h5678, 16'h5678};
    vecs[14] = '{0, OP_RSVD,  6'd0,  16'h1234, 16'h5678, 16'h0000};
    vecs[15] = '{1, OP_ADD,   6'd14, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[16] = '{0, OP_SRA,   6'd15, 16'h7FF0, 16'h0004, 16'h07FF};

    clearInputs();
    step();
    step();
    checkOutput("reset forward0", bus.forward0, 0);
    checkOutput("reset forward1", bus.forward1, 0);
    checkOutput("reset forwardDiv", bus.forwardDiv, 0);
    checkOutput("reset busy", {bus.busy0, bus.busy1, bus.divBusy, bus.dropErr}, 0);

    // First issue goes in the same cycle reset is released.
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      clearInputs();
      applyStimulus(vecs[i].lane, vecs[i].op, vecs[i].tag, vecs[i].a, vecs[i].b);
      step();
      checkOutput($sformatf("vec%0d active lane", i),
                  (vecs[i].lane == 0) ? bus.forward0 : bus.forward1,
                  busVal(vecs[i].tag, vecs[i].want));
      checkOutput($sformatf("vec%0d other lane", i),
                  (vecs[i].lane == 0) ? bus.forward1 : bus.forward0, 0);
    end
    clearInputs();
    step();
    checkOutput("idle forward0", bus.forward0, 0);
    checkOutput("idle forward1", bus.forward1, 0);

    applyStimulus(0, OP_ADD, 6'd5, 16'h7FFF, 16'h0001);
    step();
    clearInputs();
    checkOutput("add pulse", bus.forward0, 23'h458000);
    step();
    checkOutput("add pulse end", bus.forward0, 0);

    runDiv(0, OP_DIVU, 6'd3, 16'd100, 16'd7, 16'h000E, "divu 100/7");
    runDiv(1, OP_REMU, 6'd4, 16'd100, 16'd7, 16'h0002, "remu 100/7");
    runDiv(0, OP_DIVU, 6'd33, 16'h1234, 16'h0000, 16'hFFFF, "divu by zero");
    runDiv(1, OP_REMU, 6'd34, 16'h1234, 16'h0000, 16'h1234, "remu by zero");
    step();
    checkOutput("div pulse end", bus.forwardDiv, 0);
    checkOutput("no drops yet", bus.dropErr, 0);

    // Multiply on both lanes, with a colliding ADD on lane 1.
    applyStimulus(1, OP_MUL, 6'd9, 16'h0100, 16'h0101);
    applyStimulus(0, OP_MUL, 6'd12, 16'h1234, 16'h0010);
    step();
    clearInputs();
    checkOutput("mul busy1", bus.busy1, 1);
    checkOutput("mul busy0", bus.busy0, 1);
    checkOutput("mul stage1 forward1", bus.forward1, 0);
    checkOutput("mul stage1 forward0", bus.forward0, 0);
    checkOutput("mul dropErr before", bus.dropErr, 0);
    applyStimulus(1, OP_ADD, 6'd10, 16'd1, 16'd1);
    step();
    clearInputs();
    checkOutput("mul forward1", bus.forward1, busVal(6'd9, 16'h0100));
    checkOutput("mul forward0", bus.forward0, busVal(6'd12, 16'h2340));
    checkOutput("mul busy1 clear", bus.busy1, 0);
    checkOutput("dropped add dropErr", bus.dropErr, 1);
    applyStimulus(0, OP_SUB, 6'd13, 16'd5, 16'd3);
    step();
    clearInputs();
    checkOutput("dropped add no result", bus.forward1, 0);
    checkOutput("after mul lane0", bus.forward0, busVal(6'd13, 16'h0002));

    rst_n = 1'b0;
    #1;
    checkOutput("reset clears dropErr", bus.dropErr, 0);
    step();
    rst_n = 1'b1;

    // Both lanes request the divider; a later request while busy is also dropped.
    applyStimulus(0, OP_DIVU, 6'd7, 16'd200, 16'd10);
    applyStimulus(1, OP_DIVU, 6'd8, 16'd50, 16'd5);
    step();
    clearInputs();
    checkOutput("dual div dropErr", bus.dropErr, 1);
    step();
    step();
    applyStimulus(0, OP_DIVU, 6'd11, 16'd9, 16'd3);
    step();
    clearInputs();
    for (int k = 0; k < 12; k++) step();
    checkOutput("dual div not yet", bus.forwardDiv, 0);
    step();
    checkOutput("dual div lane0 wins", bus.forwardDiv, busVal(6'd7, 16'h0014));
    for (int k = 0; k < 20; k++) begin
      step();
      checkOutput("dual div no extra result", bus.forwardDiv, 0);
    end

    // Reset in the middle of a divide aborts it.
    applyStimulus(0, OP_DIVU, 6'd20, 16'd100, 16'd7);
    step();
    clearInputs();
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    checkOutput("abort divBusy", bus.divBusy, 0);
    checkOutput("abort dropErr", bus.dropErr, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checkOutput("abort forwardDiv", {bus.divBusy, bus.forwardDiv}, 0);
    end

    // Reset in the middle of a multiply aborts it.
    applyStimulus(0, OP_MUL, 6'd21, 16'd3, 16'd3);
    step();
    clearInputs();
    rst_n = 1'b0;
    step();
    checkOutput("mul abort busy0", bus.busy0, 0);
    rst_n = 1'b1;
    applyStimulus(0, OP_ADD, 6'd1, 16'd2, 16'd3);
    step();
    clearInputs();
    checkOutput("post-reset add", bus.forward0, busVal(6'd1, 16'h0005));
    step();
    checkOutput("mul abort no result", bus.forward0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
